// File: rtl/ictlb_fwd_arb.sv
// ICTLB forward-port arbiter: core PC requests win over prefetches, a starvation
// counter forces a waiting prefetch through, and a 2-entry FIFO absorbs downstream retry.
module ictlb_fwd_arb #(
    parameter int CoreIdBits = 5,
    parameter int PfMaxWait  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_valid,
    output logic                  pc_retry,
    input  logic [CoreIdBits-1:0] pc_coreid,
    input  logic [10:0]           pc_laddr,
    input  logic                  pf_valid,
    output logic                  pf_retry,
    input  logic                  pf_l2,
    input  logic [10:0]           pf_laddr,
    output logic                  fwd_valid,
    input  logic                  fwd_retry,
    output logic [CoreIdBits-1:0] fwd_coreid,
    output logic                  fwd_prefetch,
    output logic                  fwd_fault,
    output logic [10:0]           fwd_hpaadr,
    output logic [2:0]            fwd_ppaadr
);

    localparam int                    StarveBits = $clog2(PfMaxWait + 1);
    localparam logic [StarveBits-1:0] StarveMax  = StarveBits'(PfMaxWait);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CORE,
        GNT_PF
    } gnt_e;

    typedef struct packed {
        logic [CoreIdBits-1:0] coreid;
        logic                  prefetch;
        logic [10:0]           laddr;
    } entry_t;

    entry_t                mem [2];
    entry_t                push_entry;
    entry_t                head;
    logic [1:0]            count;
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [StarveBits-1:0] starve;
    gnt_e                  gnt;
    logic                  full;
    logic                  pfw;
    logic                  push;
    logic                  pop;

    // full comes from registered count only, so fwd_retry never reaches pc/pf_retry
    assign full = (count == 2'd2);
    assign pfw  = pf_valid & ~pf_l2;
    assign push = (gnt != GNT_NONE);
    assign pop  = fwd_valid & ~fwd_retry;

    always_comb begin
        gnt = GNT_NONE;
        if (!full) begin
            if (pc_valid && (!pfw || starve < StarveMax)) begin
                gnt = GNT_CORE;
            end else if (pfw) begin
                gnt = GNT_PF;
            end
        end
    end

    always_comb begin
        pc_retry = pc_valid & (gnt != GNT_CORE);
        pf_retry = pfw & (gnt != GNT_PF);
    end

    always_comb begin
        push_entry.coreid   = pc_coreid;
        push_entry.prefetch = 1'b0;
        push_entry.laddr    = pc_laddr;
        if (gnt == GNT_PF) begin
            push_entry.coreid   = '0;
            push_entry.prefetch = 1'b1;
            push_entry.laddr    = pf_laddr;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve <= '0;
        end else if (gnt == GNT_PF) begin
            starve <= '0;
        end else if (gnt == GNT_CORE && pfw && starve < StarveMax) begin
            starve <= starve + StarveBits'(1);
        end
    end

    // Payload is gated so it reads zero whenever no entry is presented
    always_comb begin
        head         = mem[rd_ptr];
        fwd_valid    = (count != 2'd0);
        fwd_coreid   = fwd_valid ? head.coreid : '0;
        fwd_prefetch = fwd_valid & head.prefetch;
        fwd_fault    = 1'b0;
        fwd_hpaadr   = fwd_valid ? head.laddr : '0;
        fwd_ppaadr   = fwd_valid ? head.laddr[2:0] : '0;
    end

endmodule

// File: tb/tb_ictlb_fwd_arb.sv
// Self-checking bench for ictlb_fwd_arb: directed vector table, hand-written
// starvation/reset sequences, and randomized traffic against a queue-based model.
module tb_ictlb_fwd_arb;

    localparam int CIDW = 5;
    localparam int PFW  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            pc_valid = 1'b0;
    logic            pc_retry;
    logic [CIDW-1:0] pc_coreid = '0;
    logic [10:0]     pc_laddr = '0;
    logic            pf_valid = 1'b0;
    logic            pf_retry;
    logic            pf_l2 = 1'b0;
    logic [10:0]     pf_laddr = '0;
    logic            fwd_valid;
    logic            fwd_retry = 1'b0;
    logic [CIDW-1:0] fwd_coreid;
    logic            fwd_prefetch;
    logic            fwd_fault;
    logic [10:0]     fwd_hpaadr;
    logic [2:0]      fwd_ppaadr;

    ictlb_fwd_arb #(.CoreIdBits(CIDW), .PfMaxWait(PFW)) dut (
        .clk(clk), .reset(reset),
        .pc_valid(pc_valid), .pc_retry(pc_retry), .pc_coreid(pc_coreid), .pc_laddr(pc_laddr),
        .pf_valid(pf_valid), .pf_retry(pf_retry), .pf_l2(pf_l2), .pf_laddr(pf_laddr),
        .fwd_valid(fwd_valid), .fwd_retry(fwd_retry), .fwd_coreid(fwd_coreid),
        .fwd_prefetch(fwd_prefetch), .fwd_fault(fwd_fault), .fwd_hpaadr(fwd_hpaadr),
        .fwd_ppaadr(fwd_ppaadr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic pv, input int cid, input int pl, input logic fv,
                         input logic l2, input int fl, input logic fr);
        pc_valid  = pv;
        pc_coreid = CIDW'(cid);
        pc_laddr  = 11'(pl);
        pf_valid  = fv;
        pf_l2     = l2;
        pf_laddr  = 11'(fl);
        fwd_retry = fr;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        next_cyc();
        next_cyc();
        reset = 1'b1;
    endtask

    typedef struct {
        logic pv; int cid; int pl; logic fv; logic l2; int fl; logic fr;
        logic e_pcr; logic e_pfr; logic e_fv; int e_cid; logic e_pf; int e_hpa;
    } vec_t;

    function automatic vec_t v(input logic pv, input int cid, input int pl, input logic fv,
                               input logic l2, input int fl, input logic fr,
                               input logic epcr, input logic epfr, input logic efv,
                               input int ecid, input logic epf, input int ehpa);
        vec_t r;
        r.pv = pv; r.cid = cid; r.pl = pl; r.fv = fv; r.l2 = l2; r.fl = fl; r.fr = fr;
        r.e_pcr = epcr; r.e_pfr = epfr; r.e_fv = efv; r.e_cid = ecid; r.e_pf = epf; r.e_hpa = ehpa;
        return r;
    endfunction

    typedef struct {
        logic [CIDW-1:0] cid;
        logic            pf;
        logic [10:0]     la;
    } ent_t;

    ent_t mq[$];
    int   mstarve;
    logic m_pcr, m_pfr;

    // Spec-level reference: compare this cycle's outputs, then advance the model
    task automatic model_step();
        logic m_full, m_pfw, ev;
        int   g;
        ent_t e;
        m_full = (mq.size() == 2);
        m_pfw  = pf_valid && !pf_l2;
        g = 0;
        if (!m_full) begin
            if (pc_valid && !m_pfw)      g = 1;
            else if (m_pfw && !pc_valid) g = 2;
            else if (pc_valid && m_pfw)  g = (mstarve < PFW) ? 1 : 2;
        end
        m_pcr = pc_valid && (g != 1);
        m_pfr = m_pfw && (g != 2);
        ev = (mq.size() != 0);
        chk("rnd_pc_retry", pc_retry, m_pcr);
        chk("rnd_pf_retry", pf_retry, m_pfr);
        chk("rnd_fwd_valid", fwd_valid, ev);
        chk("rnd_fwd_fault", fwd_fault, 0);
        if (ev) begin
            chk("rnd_fwd_coreid", fwd_coreid, mq[0].cid);
            chk("rnd_fwd_prefetch", fwd_prefetch, mq[0].pf);
            chk("rnd_fwd_hpaadr", fwd_hpaadr, mq[0].la);
            chk("rnd_fwd_ppaadr", fwd_ppaadr, mq[0].la % 8);
        end
        if (ev && !fwd_retry) void'(mq.pop_front());
        if (g == 1) begin
            e.cid = pc_coreid; e.pf = 1'b0; e.la = pc_laddr;
            mq.push_back(e);
            if (m_pfw && mstarve < PFW) mstarve++;
        end else if (g == 2) begin
            e.cid = '0; e.pf = 1'b1; e.la = pf_laddr;
            mq.push_back(e);
            mstarve = 0;
        end
    endtask

    vec_t tbl[$];

    initial begin
        // Directed vectors, starting from an empty FIFO with starve=0
        tbl.push_back(v(1, 3, 'h123, 0, 0, 0, 0,     0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,         0, 0, 1, 3, 0, 'h123));
        tbl.push_back(v(1, 2, 'h010, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 2, 'h011, 0, 0, 0, 1,     0, 0, 1, 2, 0, 'h010));
        for (int i = 0; i < 4; i++)
            tbl.push_back(v(1, 2, 'h012, 0, 0, 0, 1, 1, 0, 1, 2, 0, 'h010));
        tbl.push_back(v(1, 2, 'h012, 0, 0, 0, 0,     1, 0, 1, 2, 0, 'h010));
        tbl.push_back(v(1, 2, 'h012, 0, 0, 0, 0,     0, 0, 1, 2, 0, 'h011));
        tbl.push_back(v(1, 2, 'h013, 0, 0, 0, 0,     0, 0, 1, 2, 0, 'h012));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,         0, 0, 1, 2, 0, 'h013));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0));
        tbl.push_back(v(1, 1, 'h020, 0, 0, 0, 1,     0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 1, 0, 'h055, 1,     0, 0, 1, 1, 0, 'h020));
        tbl.push_back(v(0, 0, 0, 1, 1, 'h7FF, 1,     0, 0, 1, 1, 0, 'h020));
        tbl.push_back(v(1, 4, 'h030, 1, 0, 'h066, 1, 1, 1, 1, 1, 0, 'h020));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,         0, 0, 1, 1, 0, 'h020));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,         0, 0, 1, 0, 1, 'h055));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0));

        // Reset state: outputs idle, retries follow the empty-FIFO rules
        drive(1, 9, 'h1AA, 1, 0, 'h0F0, 0);
        #2;
        @(negedge clk);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_fwd_coreid", fwd_coreid, 0);
        chk("rst_fwd_hpaadr", fwd_hpaadr, 0);
        chk("rst_fwd_ppaadr", fwd_ppaadr, 0);
        chk("rst_fwd_prefetch", fwd_prefetch, 0);
        chk("rst_pc_retry", pc_retry, 0);
        chk("rst_pf_retry", pf_retry, 1);
        do_reset();

        foreach (tbl[i]) begin
            drive(tbl[i].pv, tbl[i].cid, tbl[i].pl, tbl[i].fv, tbl[i].l2, tbl[i].fl, tbl[i].fr);
            @(negedge clk);
            chk($sformatf("vec%0d_pc_retry", i), pc_retry, tbl[i].e_pcr);
            chk($sformatf("vec%0d_pf_retry", i), pf_retry, tbl[i].e_pfr);
            chk($sformatf("vec%0d_fwd_valid", i), fwd_valid, tbl[i].e_fv);
            chk($sformatf("vec%0d_fwd_coreid", i), fwd_coreid, tbl[i].e_cid);
            chk($sformatf("vec%0d_fwd_prefetch", i), fwd_prefetch, tbl[i].e_pf);
            chk($sformatf("vec%0d_fwd_hpaadr", i), fwd_hpaadr, tbl[i].e_hpa);
            chk($sformatf("vec%0d_fwd_ppaadr", i), fwd_ppaadr, tbl[i].e_hpa % 8);
            chk($sformatf("vec%0d_fwd_fault", i), fwd_fault, 0);
            next_cyc();
        end

        // Starvation: both requesters held, grants go C,C,C,C,P with one transfer per cycle
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1, 7, 'h100, 1, 0, 'h3C0, 0);
            @(negedge clk);
            chk($sformatf("stv%0d_pc_retry", i), pc_retry, (i % 5) == 4);
            chk($sformatf("stv%0d_pf_retry", i), pf_retry, (i % 5) != 4);
            if (i >= 1) begin
                chk($sformatf("stv%0d_fwd_valid", i), fwd_valid, 1);
                chk($sformatf("stv%0d_fwd_prefetch", i), fwd_prefetch, ((i - 1) % 5) == 4);
                chk($sformatf("stv%0d_fwd_coreid", i), fwd_coreid, (((i - 1) % 5) == 4) ? 0 : 7);
                chk($sformatf("stv%0d_fwd_hpaadr", i), fwd_hpaadr,
                    (((i - 1) % 5) == 4) ? 'h3C0 : 'h100);
            end
            next_cyc();
        end

        // Mid-operation reset: fill FIFO while starve climbs, then reset asynchronously
        do_reset();
        drive(1, 2, 'h0A0, 1, 0, 'h0B0, 1);
        next_cyc();
        next_cyc();
        @(negedge clk);
        chk("mr_full_pc_retry", pc_retry, 1);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("mr_async_fwd_valid", fwd_valid, 0);
        chk("mr_async_fwd_coreid", fwd_coreid, 0);
        chk("mr_async_fwd_hpaadr", fwd_hpaadr, 0);
        chk("mr_async_pc_retry", pc_retry, 0);
        chk("mr_async_pf_retry", pf_retry, 1);
        next_cyc();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1, 1, 'h0C1, 1, 0, 'h0B0, 0);
            @(negedge clk);
            chk($sformatf("mr%0d_pc_retry", i), pc_retry, i == 4);
            if (i == 0) chk("mr0_fwd_valid", fwd_valid, 0);
            if (i == 1) begin
                chk("mr1_fwd_valid", fwd_valid, 1);
                chk("mr1_fwd_coreid", fwd_coreid, 1);
                chk("mr1_fwd_hpaadr", fwd_hpaadr, 'h0C1);
                chk("mr1_fwd_prefetch", fwd_prefetch, 0);
            end
            next_cyc();
        end

        // Randomized traffic against the queue model, honouring hold-while-retried
        do_reset();
        mq.delete();
        mstarve = 0;
        m_pcr = 1'b0;
        m_pfr = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if (!(pc_valid && m_pcr)) begin
                pc_valid  = ($urandom_range(0, 99) < 70);
                pc_coreid = CIDW'($urandom);
                pc_laddr  = 11'($urandom);
            end
            if (!(pf_valid && m_pfr)) begin
                pf_valid = ($urandom_range(0, 99) < 55);
                pf_l2    = ($urandom_range(0, 3) == 0);
                pf_laddr = 11'($urandom);
            end
            fwd_retry = ($urandom_range(0, 99) < 35);
            @(negedge clk);
            model_step();
            next_cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ictlb_fwd_arb.md
Name: ictlb_fwd_arb

Overview:
Arbiter and output buffer for the ICTLB forward port toward the L1 instruction cache. It shares the single l1tlbtol1_fwd channel between core PC translation requests and opportunistic prefetch requests. Core requests have priority, and a starvation counter guarantees prefetch forward progress. A 2-entry registered FIFO decouples both requesters from downstream retry.

Parameters:
CoreIdBits, 5, width of coreid field
PfMaxWait, 4, consecutive core grants a waiting prefetch tolerates before it is forced ahead (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
pc_valid  in  1  core PC request valid
pc_retry  out  1  core request not accepted this cycle
pc_coreid  in  CoreIdBits  requesting core
pc_laddr  in  11  linear address bits [22:12]
pf_valid  in  1  prefetch request valid
pf_retry  out  1  prefetch not accepted this cycle
pf_l2  in  1  prefetch targets L2 only; not forwarded
pf_laddr  in  11  linear address bits [22:12]
fwd_valid  out  1  forward entry valid
fwd_retry  in  1  downstream stall
fwd_coreid  out  CoreIdBits  coreid (0 for prefetch)
fwd_prefetch  out  1  1 = prefetch-originated
fwd_fault  out  1  always 0
fwd_hpaadr  out  11  = laddr[22:12]
fwd_ppaadr  out  3  = laddr[14:12], i.e. low 3 bits of the 11-bit laddr input

Behaviour:
- Handshake: a transfer occurs when valid=1 and retry=0 in the same cycle. A requester holds valid and payload stable while retry=1. Downstream holds the same rules on fwd_*.
- FIFO: 2 entries, count 0..2, registered. fwd_valid = (count!=0). fwd_* is driven from the head entry.
  - Pop when fwd_valid & ~fwd_retry.
  - Push when an input is granted.
  - Push and pop in the same cycle are allowed; count is unchanged.
- full = (count==2), taken from registered state only. A pop in the same cycle does not free a slot; this cuts the fwd_retry to pc/pf_retry path.
- pf_l2=1 prefetch: pf_retry=0 immediately. The request is consumed and discarded, with no FIFO push and no effect on the starvation counter. This holds even when full.
- Forwardable prefetch (pf_valid & ~pf_l2) is called pfw.
- Grant rules when ~full:
  - pc_valid & ~pfw: grant core.
  - pfw & ~pc_valid: grant prefetch.
  - Both valid and starve<PfMaxWait: grant core; prefetch sees retry.
  - Both valid and starve==PfMaxWait: grant prefetch; core sees retry.
- When full: pc_retry=pc_valid; pf_retry=pfw.
- pc_retry and pf_retry are 0 whenever the corresponding valid is 0.
- starve counter, width clog2(PfMaxWait+1):
  - Increments on a core grant while pfw=1.
  - Clears on a prefetch grant.
  - Holds otherwise, including when full and when pfw drops without a grant.
  - Saturates at PfMaxWait.
- Entry formats:
  - Core entry: coreid=pc_coreid, prefetch=0, fault=0.
  - Prefetch entry: coreid=0, prefetch=1, fault=0.
- Latency: a grant in cycle N appears on fwd_valid at N+1 when the FIFO was empty. Ordering is strictly FIFO; no drop or duplicate.
- Reset (reset=0, async): count=0, pointers=0, starve=0, fwd_valid=0. All fwd payload outputs are 0. pc_retry/pf_retry follow their combinational rules with full=0. Reset mid-operation discards buffered entries. Operation resumes on the first clk edge after reset deasserts.

Test Plan:
1. pc_valid one cycle, coreid=3, laddr=0x123, FIFO empty, fwd_retry=0 -> next cycle fwd_valid=1, coreid=3, hpaadr=0x123, ppaadr=3, prefetch=0, fault=0; pc_retry=0.
2. PfMaxWait=4; pc_valid and pfw held continuously; fwd_retry=0 -> grant sequence C,C,C,C,P repeats. The prefetch entry has prefetch=1 and coreid=0. pc_retry=1 exactly on the P cycles.
3. Core streams laddr 0x010,0x011,0x012,0x013 with fwd_retry=1 for 6 cycles:
   - 0x010 and 0x011 are accepted, then pc_retry=1 while full.
   - After fwd_retry drops: output order 0x010,0x011,0x012,0x013, each exactly once.
   - No push is accepted in the first pop cycle.
4. pf_valid=1, pf_l2=1, laddr=0x7FF with FIFO full -> pf_retry=0, no fwd entry, starve unchanged.
5. Fill FIFO (count=2), assert reset low mid-cycle -> fwd_valid=0 immediately without a clock. After release, a new core request (coreid=1) is the first fwd output and starve=0.
6. Steady stream with fwd_retry=0 -> one transfer per cycle, count stays 1, pc_retry never 1.
